// File: rtl/cordic_pkg.sv
// Shared types and number formats for the CORDIC request scheduler and its result FIFO.
package cordic_pkg;
   localparam int ANGLE_INT = 8;
   localparam int ANGLE_FRAC = 12;
   localparam int ANGLE_W = ANGLE_INT + ANGLE_FRAC;   // Q8.12 degrees
   localparam int XY_INT = 3;
   localparam int XY_FRAC = 5;
   localparam int XY_W = XY_INT + XY_FRAC;            // Q3.5
   localparam int ID_MAX_W = 4;

   typedef struct packed {
      logic [ID_MAX_W-1:0]    id;
      logic signed [XY_W-1:0] cos;
      logic signed [XY_W-1:0] sin;
   } res_entry_t;

   localparam int ENTRY_W = $bits(res_entry_t);
endpackage

// File: rtl/cordic_res_fifo.sv
// Single-clock result FIFO; a write into a full FIFO is taken only when a pop frees a slot the same cycle.
module cordic_res_fifo
   import cordic_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ENTRY_W-1:0]       din,
   input  logic                     rd_en,
   output logic [ENTRY_W-1:0]       dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW:0]        wptr_q, rptr_q;
   logic               do_wr, do_rd;

   assign count = wptr_q - rptr_q;
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);
   // Head is forced to zero when empty so outputs are clean out of reset.
   assign dout  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC core among NREQ requesters.
// Credits count in-flight plus buffered results, so every launch has a guaranteed FIFO slot.
module cordic_sched
   import cordic_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int LAT    = 12,
   parameter int FDEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ANGLE_W-1:0]  req_angle,
   output logic [NREQ-1:0]          req_ready,
   output logic                     core_start,
   output logic [ANGLE_W-1:0]       core_angle,
   input  logic [XY_W-1:0]          core_x,
   input  logic [XY_W-1:0]          core_y,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic [XY_W-1:0]          res_cos,
   output logic [XY_W-1:0]          res_sin
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(FDEPTH) + 1;

   logic [IDW-1:0]     last_grant_q, last_grant_d;
   logic [CW-1:0]      credit_q, credit_d;
   logic               core_start_q;
   logic [ANGLE_W-1:0] core_angle_q, core_angle_d;
   logic [IDW:0]       tag_q [LAT+1];

   logic [IDW-1:0]     cand, gnt_id;
   logic               gnt_found, credit_ok, accept, pop;
   logic [ANGLE_W-1:0] gnt_angle;

   res_entry_t         wr_entry, head;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_empty, fifo_full;
   logic [CW-1:0]      fifo_count;
   logic               unused_sink;

   always_comb begin
      cand      = last_grant_q;
      gnt_id    = '0;
      gnt_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   always_comb begin
      gnt_angle = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_id == IDW'(k)) gnt_angle = req_angle[k*ANGLE_W +: ANGLE_W];
      end
   end

   assign credit_ok = (credit_q != CW'(FDEPTH));
   assign accept    = !reset && credit_ok && gnt_found;
   assign pop       = res_valid && res_ready;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_id] = 1'b1;
   end

   always_comb begin
      last_grant_d = accept ? gnt_id : last_grant_q;
      core_angle_d = accept ? gnt_angle : core_angle_q;
      credit_d     = credit_q;
      if (accept && !pop)      credit_d = credit_q + 1'b1;
      else if (pop && !accept) credit_d = credit_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= IDW'(NREQ - 1);
         credit_q     <= '0;
         core_start_q <= 1'b0;
         core_angle_q <= '0;
         for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         credit_q     <= credit_d;
         core_start_q <= accept;
         core_angle_q <= core_angle_d;
         // Stage LAT lines up with the core result of the launch one cycle after accept.
         tag_q[0]     <= {accept, gnt_id};
         for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   always_comb begin
      wr_entry.id  = ID_MAX_W'(tag_q[LAT][IDW-1:0]);
      wr_entry.cos = core_x;
      wr_entry.sin = core_y;
   end

   cordic_res_fifo #(.DEPTH(FDEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (tag_q[LAT][IDW]),
      .din   (wr_entry),
      .rd_en (res_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head        = fifo_dout;
   assign core_start  = core_start_q;
   assign core_angle  = core_angle_q;
   assign res_valid   = !fifo_empty;
   assign res_id      = head.id[IDW-1:0];
   assign res_cos     = head.cos;
   assign res_sin     = head.sin;
   assign unused_sink = ^{fifo_full, fifo_count, head.id};
endmodule

// File: tb/tb_cordic_sched.sv
// Directed and randomized checks of cordic_sched against a behavioural fixed-latency core.
module tb_cordic_sched;
   localparam int NREQ   = 4;
   localparam int LAT    = 12;
   localparam int FDEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [79:0] req_angle;
   logic [3:0]  req_ready;
   logic        core_start;
   logic [19:0] core_angle;
   logic [7:0]  core_x, core_y;
   logic        res_valid, res_ready;
   logic [1:0]  res_id;
   logic [7:0]  res_cos, res_sin;

   int n_checks = 0;
   int n_pass   = 0;
   logic [19:0] ang [NREQ];
   logic [19:0] core_pipe [LAT];

   cordic_sched #(.NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
      .core_start(core_start), .core_angle(core_angle),
      .core_x(core_x), .core_y(core_y),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_cos(res_cos), .res_sin(res_sin)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fx(input logic [19:0] a);
      return a[19:12] ^ a[7:0];
   endfunction

   function automatic logic [7:0] fy(input logic [19:0] a);
      return a[11:4] + 8'h05;
   endfunction

   // Core model: result of the angle launched in cycle s is presented in cycle s+LAT.
   always @(posedge clk) begin
      core_pipe[0] <= core_angle;
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_x = fx(core_pipe[LAT-1]);
   assign core_y = fy(core_pipe[LAT-1]);

   task automatic pack_angles();
      req_angle = {ang[3], ang[2], ang[1], ang[0]};
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = '0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
      n_checks++; if (core_start !== 1'b0) $display("FAIL reset_core_start: got %b want 0", core_start); else n_pass++;
      n_checks++; if (core_angle !== 20'h0) $display("FAIL reset_core_angle: got %h want 0", core_angle); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
      n_checks++; if (res_id !== 2'd0) $display("FAIL reset_res_id: got %0d want 0", res_id); else n_pass++;
      n_checks++; if (res_cos !== 8'h00) $display("FAIL reset_res_cos: got %h want 00", res_cos); else n_pass++;
      n_checks++; if (res_sin !== 8'h00) $display("FAIL reset_res_sin: got %h want 00", res_sin); else n_pass++;
   endtask

   task automatic test_single();
      int seen;
      do_reset();
      ang[0] = 20'h2D000; ang[1] = 20'h0; ang[2] = 20'h0; ang[3] = 20'h0;
      pack_angles();
      req_valid = 4'b0001; res_ready = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (core_start !== 1'b1) $display("FAIL single_core_start: got %b want 1", core_start); else n_pass++;
      n_checks++; if (core_angle !== 20'h2D000) $display("FAIL single_core_angle: got %h want 2d000", core_angle); else n_pass++;
      @(negedge clk);
      n_checks++; if (core_start !== 1'b0) $display("FAIL single_start_strobe: got %b want 0", core_start); else n_pass++;
      seen = (res_valid === 1'b1) ? 2 : -1;
      for (int k = 3; k <= LAT + 6; k++) begin
         @(negedge clk);
         if (seen < 0 && res_valid === 1'b1) seen = k;
      end
      n_checks++; if (seen != LAT + 2) $display("FAIL single_latency: got %0d want %0d", seen, LAT + 2); else n_pass++;
      n_checks++; if (res_id !== 2'd0) $display("FAIL single_res_id: got %0d want 0", res_id); else n_pass++;
      n_checks++; if (res_cos !== 8'h2D) $display("FAIL single_res_cos: got %h want 2d", res_cos); else n_pass++;
      n_checks++; if (res_sin !== 8'h05) $display("FAIL single_res_sin: got %h want 05", res_sin); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_cos !== 8'h2D || res_sin !== 8'h05)
         $display("FAIL single_hold: got v=%b cos=%h sin=%h want v=1 cos=2d sin=05", res_valid, res_cos, res_sin);
      else n_pass++;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL single_pop: got res_valid=%b want 0", res_valid); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [3:0] want;
      int got;
      do_reset();
      ang[0] = 20'h8A5C3; ang[1] = 20'h12345; ang[2] = 20'hF0F0F; ang[3] = 20'h00C81;
      pack_angles();
      req_valid = 4'hF; res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         want = 4'b0001 << (i % 4);
         #1;
         n_checks++; if (req_ready !== want) $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, want); else n_pass++;
         @(negedge clk);
      end
      req_valid = '0;
      got = 0;
      for (int c = 0; c < 60 && got < 12; c++) begin
         #1;
         if (res_valid === 1'b1) begin
            n_checks++; if (res_id !== 2'(got % 4)) $display("FAIL rr_res_id[%0d]: got %0d want %0d", got, res_id, got % 4); else n_pass++;
            n_checks++; if (res_cos !== fx(ang[got % 4])) $display("FAIL rr_res_cos[%0d]: got %h want %h", got, res_cos, fx(ang[got % 4])); else n_pass++;
            n_checks++; if (res_sin !== fy(ang[got % 4])) $display("FAIL rr_res_sin[%0d]: got %h want %h", got, res_sin, fy(ang[got % 4])); else n_pass++;
            got++;
         end
         @(negedge clk);
      end
      n_checks++; if (got != 12) $display("FAIL rr_result_count: got %0d want 12", got); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [3:0] want;
      int acc, got, extra;
      do_reset();
      ang[0] = 20'h8A5C3; ang[1] = 20'h12345; ang[2] = 20'hF0F0F; ang[3] = 20'h00C81;
      pack_angles();
      req_valid = 4'hF; res_ready = 1'b0; acc = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            want = 4'b0001 << (acc % 4);
            n_checks++; if (req_ready !== want) $display("FAIL bp_grant[%0d]: got %b want %b", acc, req_ready, want); else n_pass++;
            acc++;
         end
         @(negedge clk);
      end
      #1;
      n_checks++; if (acc != FDEPTH) $display("FAIL bp_accepts_until_full: got %0d want %0d", acc, FDEPTH); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_blocked: got %b want 0000", req_ready); else n_pass++;
      n_checks++; if (res_valid !== 1'b1) $display("FAIL bp_full_valid: got %b want 1", res_valid); else n_pass++;
      n_checks++; if (res_id !== 2'd0 || res_cos !== fx(ang[0])) $display("FAIL bp_head: got id=%0d cos=%h want id=0 cos=%h", res_id, res_cos, fx(ang[0])); else n_pass++;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      got = 1; extra = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            want = 4'b0001 << (acc % 4);
            n_checks++; if (req_ready !== want) $display("FAIL bp_extra_grant: got %b want %b", req_ready, want); else n_pass++;
            acc++; extra++;
         end
         @(negedge clk);
      end
      n_checks++; if (extra != 1) $display("FAIL bp_one_more_grant: got %0d want 1", extra); else n_pass++;
      res_ready = 1'b1;
      for (int c = 0; c < 120; c++) begin
         if (c == 20) req_valid = '0;
         #1;
         if (req_ready !== 4'b0000) begin
            want = 4'b0001 << (acc % 4);
            n_checks++; if (req_ready !== want) $display("FAIL bp_steady_grant[%0d]: got %b want %b", acc, req_ready, want); else n_pass++;
            acc++;
         end
         if (res_valid === 1'b1) begin
            n_checks++;
            if (res_id !== 2'(got % 4) || res_cos !== fx(ang[got % 4]) || res_sin !== fy(ang[got % 4]))
               $display("FAIL bp_order[%0d]: got id=%0d cos=%h sin=%h want id=%0d cos=%h sin=%h",
                        got, res_id, res_cos, res_sin, got % 4, fx(ang[got % 4]), fy(ang[got % 4]));
            else n_pass++;
            got++;
         end
         @(negedge clk);
      end
      n_checks++; if (got != acc) $display("FAIL bp_drain_count: got %0d results want %0d", got, acc); else n_pass++;
      #1;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL bp_empty_after_drain: got %b want 0", res_valid); else n_pass++;
   endtask

   task automatic test_reset_midflight();
      int seen;
      do_reset();
      ang[0] = 20'h11111; ang[1] = 20'h22222; ang[2] = 20'h33333; ang[3] = 20'h44444;
      pack_angles();
      req_valid = 4'hF; res_ready = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1; req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         #1;
         if (res_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      n_checks++; if (seen != 0) $display("FAIL midreset_discard: got %0d valid cycles want 0", seen); else n_pass++;
      req_valid = 4'hF;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL midreset_first_grant: got %b want 0001", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_stress();
      logic [17:0] exp_q [$];
      logic [17:0] head, prev;
      logic [3:0]  want, rv;
      logic [19:0] a;
      int last, credit, n_req, idx;
      logic hold;
      do_reset();
      last = NREQ - 1; credit = 0; n_req = 0; hold = 1'b0; prev = '0;
      for (int c = 0; c < 60000 && n_req < 10000; c++) begin
         rv = 4'($urandom_range(0, 15));
         req_valid = rv;
         for (int k = 0; k < NREQ; k++) ang[k] = 20'($urandom);
         pack_angles();
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         want = '0; idx = -1;
         if (credit < FDEPTH) begin
            for (int k = 1; k <= NREQ; k++)
               if (idx < 0 && rv[2'((last + k) % NREQ)]) idx = (last + k) % NREQ;
         end
         if (idx >= 0) want[2'(idx)] = 1'b1;
         n_checks++; if (req_ready !== want) $display("FAIL stress_grant c=%0d: got %b want %b", c, req_ready, want); else n_pass++;
         if (hold) begin
            n_checks++;
            if (res_valid !== 1'b1 || {res_id, res_cos, res_sin} !== prev)
               $display("FAIL stress_hold c=%0d: got v=%b %h want v=1 %h", c, res_valid, {res_id, res_cos, res_sin}, prev);
            else n_pass++;
         end
         if (res_valid === 1'b1 && res_ready) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL stress_pop c=%0d: got unexpected %h want nothing", c, {res_id, res_cos, res_sin});
            else begin
               head = exp_q.pop_front();
               if ({res_id, res_cos, res_sin} !== head) $display("FAIL stress_pop c=%0d: got %h want %h", c, {res_id, res_cos, res_sin}, head);
               else n_pass++;
            end
            credit--;
         end
         if (idx >= 0) begin
            a = ang[idx];
            exp_q.push_back({2'(idx), fx(a), fy(a)});
            last = idx; credit++; n_req++;
         end
         hold = (res_valid === 1'b1) && !res_ready;
         prev = {res_id, res_cos, res_sin};
         @(negedge clk);
      end
      n_checks++; if (n_req != 10000) $display("FAIL stress_request_count: got %0d want 10000", n_req); else n_pass++;
      req_valid = '0; res_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (res_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL stress_drain: got unexpected %h want nothing", {res_id, res_cos, res_sin});
            else begin
               head = exp_q.pop_front();
               if ({res_id, res_cos, res_sin} !== head) $display("FAIL stress_drain: got %h want %h", {res_id, res_cos, res_sin}, head);
               else n_pass++;
            end
         end
         @(negedge clk);
      end
      n_checks++; if (exp_q.size() != 0) $display("FAIL stress_lost: got %0d outstanding want 0", exp_q.size()); else n_pass++;
      #1;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL stress_final_empty: got %b want 0", res_valid); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 4'hF;
      res_ready = 1'b1;
      ang[0] = 20'hABCDE; ang[1] = 20'h12345; ang[2] = 20'h55555; ang[3] = 20'hFFFFF;
      pack_angles();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_midflight();
      test_stress();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
